// File: rtl/packet_stream_pkg.sv
// Shared types for the packet stream reader: FSM states, queued beat record
// and the final-beat keep mask helper.
package packet_stream_pkg;

  // Beats are sized for the widest legal stream; narrower builds use the low bits.
  localparam int beat_data_max_lp = 64;
  localparam int beat_keep_max_lp = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    ACK   = 2'd3
  } state_e;

  typedef struct packed {
    logic [beat_data_max_lp-1:0] data;
    logic [beat_keep_max_lp-1:0] keep;
    logic                        last;
  } beat_s;

  localparam int beat_width_lp = $bits(beat_s);

  // Byte-valid mask of the final word of a packet of 'size' bytes.
  function automatic logic [beat_keep_max_lp-1:0] keep_mask(input logic [15:0] size,
                                                            input int bytes);
    logic [15:0]                 rem;
    logic [beat_keep_max_lp-1:0] mask;
    rem  = size & (16'(bytes) - 16'd1);
    mask = '0;
    for (int i = 0; i < beat_keep_max_lp; i++) begin
      if (i < bytes && (rem == 16'd0 || i < int'(rem))) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/packet_stream_reader_queue.sv
// Two-entry beat queue between the buffer read port and the output stream;
// the head entry is held in a register so it stays stable under back-pressure.
module packet_stream_reader_queue
  import packet_stream_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     i_enq,
  input  logic [beat_width_lp-1:0] i_beat,
  input  logic                     i_deq,
  output logic [beat_width_lp-1:0] o_beat,
  output logic                     o_valid,
  output logic [1:0]               o_count
);

  logic [beat_width_lp-1:0] r_mem [2];
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [1:0]               r_count;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else begin
      if (i_enq) begin
        r_mem[r_wr_ptr] <= i_beat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_deq) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_enq} - {1'b0, i_deq};
    end
  end

  assign o_beat  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    (i_enq && !i_deq) |-> (r_count != 2'd2));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    i_deq |-> (r_count != 2'd0));
`endif

endmodule

// File: rtl/packet_stream_reader.sv
// Drains packets from the packet buffer read port and replays them as a
// valid/ready word stream with keep/last, acking each slot after its last beat.
module packet_stream_reader
  import packet_stream_pkg::*;
#(
  parameter  int data_width_p  = 64,
  parameter  int els_p         = 2048,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int size_width_lp = $clog2(els_p + 1),
  localparam int bytes_lp      = data_width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     packet_avail_i,
  output logic                     packet_ack_o,
  output logic                     packet_rvalid_o,
  output logic [addr_width_lp-1:0] packet_raddr_o,
  input  logic [data_width_p-1:0]  packet_rdata_i,
  input  logic [size_width_lp-1:0] packet_rsize_i,
  output logic [data_width_p-1:0]  m_data_o,
  output logic [bytes_lp-1:0]      m_keep_o,
  output logic                     m_last_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i
);

  localparam int lg_bytes_lp  = $clog2(bytes_lp);
  // One extra bit so a full slot (els_p/bytes_lp words) is countable.
  localparam int cnt_width_lp = addr_width_lp - lg_bytes_lp + 1;

  state_e                   r_state;
  logic [size_width_lp-1:0] r_size;
  logic [cnt_width_lp-1:0]  r_words;
  logic [cnt_width_lp-1:0]  r_issue_cnt;
  logic                     r_inflight;
  logic                     r_tag_last;
  logic [bytes_lp-1:0]      r_tag_keep;

  logic [cnt_width_lp-1:0]  w_words_calc;
  logic [2:0]               w_pending;
  logic                     w_issue;
  logic                     w_final_issue;
  logic [beat_keep_max_lp-1:0] w_last_keep;
  logic [bytes_lp-1:0]      w_issue_keep;
  logic                     w_deq;
  logic                     w_q_valid;
  logic [1:0]               w_q_count;
  beat_s                    w_enq_beat;
  beat_s                    w_head;

  assign w_words_calc = cnt_width_lp'(({1'b0, packet_rsize_i} +
                        (size_width_lp + 1)'(bytes_lp - 1)) >> lg_bytes_lp);

  // Occupancy after this cycle's dequeue, counting the read still in flight.
  assign w_pending     = {1'b0, w_q_count} + {2'b00, r_inflight} - {2'b00, w_deq};
  assign w_issue       = (r_state == READ) && (r_issue_cnt < r_words) && (w_pending < 3'd2);
  assign w_final_issue = w_issue && (r_issue_cnt == r_words - cnt_width_lp'(1));
  assign w_last_keep   = keep_mask(16'(r_size), bytes_lp);
  assign w_issue_keep  = w_final_issue ? w_last_keep[bytes_lp-1:0] : '1;
  assign w_deq         = w_q_valid & m_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_size      <= '0;
      r_words     <= '0;
      r_issue_cnt <= '0;
      r_inflight  <= 1'b0;
      r_tag_last  <= 1'b0;
      r_tag_keep  <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + cnt_width_lp'(1);
        r_tag_last  <= w_final_issue;
        r_tag_keep  <= w_issue_keep;
      end
      case (r_state)
        IDLE: begin
          if (packet_avail_i) begin
            r_size      <= packet_rsize_i;
            r_words     <= w_words_calc;
            r_issue_cnt <= '0;
            r_state     <= (packet_rsize_i == '0) ? ACK : READ;
          end
        end
        READ:    if (w_final_issue) r_state <= DRAIN;
        DRAIN:   if (w_deq && m_last_o) r_state <= ACK;
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_enq_beat      = '0;
    w_enq_beat.data = beat_data_max_lp'(packet_rdata_i);
    w_enq_beat.keep = beat_keep_max_lp'(r_tag_keep);
    w_enq_beat.last = r_tag_last;
  end

  packet_stream_reader_queue u_queue (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_enq   (r_inflight),
    .i_beat  (w_enq_beat),
    .i_deq   (w_deq),
    .o_beat  (w_head),
    .o_valid (w_q_valid),
    .o_count (w_q_count)
  );

  assign packet_ack_o    = (r_state == ACK);
  assign packet_rvalid_o = w_issue;
  assign packet_raddr_o  = {r_issue_cnt[cnt_width_lp-2:0], {lg_bytes_lp{1'b0}}};
  assign m_data_o        = w_head.data[data_width_p-1:0];
  assign m_keep_o        = w_head.keep[bytes_lp-1:0];
  assign m_last_o        = w_head.last;
  assign m_valid_o       = w_q_valid;

`ifndef SYNTHESIS
  a_width_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    (data_width_p == 32 || data_width_p == 64));
  a_size_range: assert property (@(posedge clk_i) disable iff (reset_i)
    (32'(r_size) <= els_p));
  a_raddr_aligned: assert property (@(posedge clk_i) disable iff (reset_i)
    packet_rvalid_o |-> (packet_raddr_o[lg_bytes_lp-1:0] == '0));
  a_avail_held: assert property (@(posedge clk_i) disable iff (reset_i)
    (r_state != IDLE) |-> packet_avail_i);
`endif

endmodule

// File: tb/tb_packet_stream_reader.sv
// Bench for packet_stream_reader: a buffer model answers reads and a per-beat
// reference derives data, keep, last and timing from packet sizes alone.
module tb_packet_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        avail, ack, rvalid, m_last, m_valid, m_ready;
  logic [10:0] raddr;
  logic [63:0] rdata, m_data;
  logic [11:0] rsize;
  logic [7:0]  m_keep;

  logic        avail32, ack32, rvalid32, m_last32, m_valid32, m_ready32;
  logic [10:0] raddr32;
  logic [31:0] rdata32, m_data32;
  logic [11:0] rsize32;
  logic [3:0]  m_keep32;

  packet_stream_reader #(.data_width_p(64), .els_p(2048)) u_dut (
    .clk_i(clk), .reset_i(rst), .packet_avail_i(avail), .packet_ack_o(ack),
    .packet_rvalid_o(rvalid), .packet_raddr_o(raddr), .packet_rdata_i(rdata),
    .packet_rsize_i(rsize), .m_data_o(m_data), .m_keep_o(m_keep),
    .m_last_o(m_last), .m_valid_o(m_valid), .m_ready_i(m_ready));

  packet_stream_reader #(.data_width_p(32), .els_p(2048)) u_dut32 (
    .clk_i(clk), .reset_i(rst), .packet_avail_i(avail32), .packet_ack_o(ack32),
    .packet_rvalid_o(rvalid32), .packet_raddr_o(raddr32), .packet_rdata_i(rdata32),
    .packet_rsize_i(rsize32), .m_data_o(m_data32), .m_keep_o(m_keep32),
    .m_last_o(m_last32), .m_valid_o(m_valid32), .m_ready_i(m_ready32));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Buffer contents: each word is a function of packet number and byte address.
  function automatic logic [63:0] mkword(input int p, input int addr);
    return {16'(p) ^ 16'hA5C3, 16'(addr), 32'(p * 1103515245 + addr * 7 + 12345)};
  endfunction

  function automatic logic [31:0] word32(input int addr);
    return 32'hC0DE0000 ^ 32'(addr * 257);
  endfunction

  function automatic int words_of(input int s);
    return (s + 7) / 8;
  endfunction

  function automatic logic [7:0] exp_keep(input int s, input int b);
    logic [7:0] k;
    for (int j = 0; j < 8; j++) k[j] = (b * 8 + j < s);
    return k;
  endfunction

  int         pkt_q[$];
  int         pid = 0;
  int         res_beats, res_acks, res_gap;
  logic [7:0] res_last_keep;

  // mode 0: ready always high; 1: ready 1,0,0 repeating; 2: random ready.
  task automatic run_pkts(input int mode);
    int cyc = 0, size = 0, words = 0, issued = 0, accepted = 0, start = 0;
    int last_hs = -10, last_iss = -10, prev_ack = -10, first_rv = -10;
    bit prev_rv = 1'b0, mv_seen = 1'b0;
    logic [10:0] prev_addr = '0;
    res_acks = 0; res_gap = -1; res_beats = 0; res_last_keep = '0;
    size = pkt_q[0]; words = words_of(size);
    while (pkt_q.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      rdata = prev_rv ? mkword(pid, int'(prev_addr)) : {$urandom, $urandom};
      avail = 1'b1;
      rsize = 12'(pkt_q[0]);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (m_valid) begin
        if (!mv_seen) begin
          mv_seen = 1'b1;
          check("first_valid_latency", cyc - start, 3);
        end
        if (accepted < words)
          check("beat", {m_data, m_keep, m_last},
                {mkword(pid, accepted * 8), exp_keep(size, accepted), accepted == words - 1});
        else
          check("extra_beat", m_valid, 1'b0);
        if (m_ready) begin
          accepted++;
          last_hs = cyc;
          res_last_keep = m_keep;
        end
      end
      if (rvalid) begin
        check("issue_bound", issued < words, 1'b1);
        check("raddr", raddr, issued * 8);
        if (issued == 0) begin
          first_rv = cyc;
          check("first_issue_latency", cyc - start, 1);
        end else if (mode == 0) begin
          check("issue_gap", cyc - last_iss, 1);
        end
        issued++;
        last_iss = cyc;
        check("occupancy_le2", (issued - accepted) <= 2, 1'b1);
      end
      prev_rv = rvalid;
      prev_addr = raddr;
      if (ack) begin
        check("ack_beats", accepted, words);
        check("ack_latency", cyc - ((words > 0) ? last_hs : start), 1);
        res_beats = accepted;
        res_acks++;
        if (prev_ack >= 0) res_gap = first_rv - prev_ack;
        prev_ack = cyc;
        pid++;
        void'(pkt_q.pop_front());
        start = cyc + 1; issued = 0; accepted = 0; mv_seen = 1'b0; first_rv = -10;
        if (pkt_q.size() > 0) begin
          size = pkt_q[0];
          words = words_of(size);
        end
      end
      cyc++;
    end
    if (pkt_q.size() > 0) begin
      check("timeout_pending_packets", pkt_q.size(), 0);
      pkt_q.delete();
    end
    @(negedge clk);
    avail = 1'b0;
    #1;
    check("idle_after_ack", {ack, rvalid, m_valid}, 3'b000);
  endtask

  typedef struct {
    int         size;
    int         mode;
    int         beats;
    logic [7:0] last_keep;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int iss32, acc32;
    bit prv32, done32;
    logic [10:0] pa32;
    logic [36:0] exp32[2];

    vecs[0] = '{24,   0, 3,   8'hFF};
    vecs[1] = '{13,   0, 2,   8'h1F};
    vecs[2] = '{0,    0, 0,   8'h00};
    vecs[3] = '{40,   1, 5,   8'hFF};
    vecs[4] = '{2048, 2, 256, 8'hFF};
    vecs[5] = '{1,    1, 1,   8'h01};
    vecs[6] = '{7,    2, 1,   8'h7F};
    vecs[7] = '{8,    0, 1,   8'hFF};
    vecs[8] = '{64,   1, 8,   8'hFF};

    rst = 1'b0; avail = 1'b0; rsize = '0; rdata = '0; m_ready = 1'b0;
    avail32 = 1'b0; rsize32 = '0; rdata32 = '0; m_ready32 = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("reset_outputs64", {ack, rvalid, raddr, m_valid, m_last, m_keep, m_data}, '0);
    check("reset_outputs32", {ack32, rvalid32, raddr32, m_valid32, m_last32, m_keep32, m_data32}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      pkt_q.push_back(vecs[i].size);
      run_pkts(vecs[i].mode);
      $display("vec %0d: size=%0d mode=%0d beats=%0d last_keep=%0h acks=%0d",
               i, vecs[i].size, vecs[i].mode, res_beats, res_last_keep, res_acks);
      check("vec_beats", res_beats, vecs[i].beats);
      check("vec_acks", res_acks, 1);
      if (vecs[i].beats > 0) check("vec_last_keep", res_last_keep, vecs[i].last_keep);
    end

    // Back-to-back packets: next read starts two cycles after the ack.
    pkt_q.push_back(16);
    pkt_q.push_back(9);
    run_pkts(0);
    $display("b2b 16,9: acks=%0d gap=%0d last_keep=%0h", res_acks, res_gap, res_last_keep);
    check("b2b_acks", res_acks, 2);
    check("b2b_gap", res_gap, 2);
    check("b2b_last_keep", res_last_keep, 8'h01);

    // Asynchronous reset in the middle of a READ, then a clean re-stream.
    @(negedge clk);
    avail = 1'b1; rsize = 12'd64; m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_read_rvalid", rvalid, 1'b1);
    #1 rst = 1'b1; avail = 1'b0;
    #1;
    check("async_reset_outputs", {ack, rvalid, raddr, m_valid, m_last, m_keep, m_data}, '0);
    @(negedge clk);
    check("reset_no_ack", ack, 1'b0);
    rst = 1'b0;
    pkt_q.push_back(64);
    run_pkts(0);
    $display("restream 64: beats=%0d acks=%0d", res_beats, res_acks);
    check("restream_beats", res_beats, 8);
    check("restream_acks", res_acks, 1);

    // 32-bit instance, size 6: keep F then 3 with last.
    exp32[0] = {word32(0), 4'hF, 1'b0};
    exp32[1] = {word32(4), 4'h3, 1'b1};
    iss32 = 0; acc32 = 0; prv32 = 1'b0; done32 = 1'b0; pa32 = '0;
    for (int c = 0; c < 20 && !done32; c++) begin
      @(negedge clk);
      rdata32 = prv32 ? word32(int'(pa32)) : $urandom;
      avail32 = 1'b1; rsize32 = 12'd6; m_ready32 = 1'b1;
      #1;
      if (m_valid32) begin
        if (acc32 < 2) check("w32_beat", {m_data32, m_keep32, m_last32}, exp32[acc32]);
        else check("w32_extra_beat", m_valid32, 1'b0);
        acc32++;
      end
      if (rvalid32) begin
        check("w32_raddr", raddr32, iss32 * 4);
        iss32++;
      end
      prv32 = rvalid32;
      pa32 = raddr32;
      if (ack32) begin
        check("w32_ack_beats", acc32, 2);
        done32 = 1'b1;
      end
    end
    $display("w32 size 6: beats=%0d issues=%0d acked=%0d", acc32, iss32, done32);
    check("w32_acked", done32, 1'b1);
    @(negedge clk);
    avail32 = 1'b0;

    // Random sizes and random back-pressure, three packets per burst.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++)
        pkt_q.push_back(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2048))
                                                    : int'($urandom_range(0, 200)));
      run_pkts(2);
      $display("random burst %0d: acks=%0d", r, res_acks);
      check("random_acks", res_acks, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
